// File: rtl/v_con_loader.sv
// v_con_loader: byte-stream command engine driving the datamem protocol port
module v_con_loader #(
  parameter int ADDR_BITS  = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  con_clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [3:0]            con_write,
  output logic [ADDR_BITS-1:0]  con_addr,
  output logic [DATA_WIDTH-1:0] con_in,
  input  logic [DATA_WIDTH-1:0] con_out,
  output logic                  busy,
  output logic                  cmd_err
);
  typedef enum logic [3:0] {IDLE, AH, AL, LEN, WDAT, WR, ACK, RADR, RCAP, RSND} state_t;
  state_t                state_q, state_d;
  logic                  rd_q, rd_d;
  logic [7:0]            ah_q, ah_d;
  logic [8:0]            cnt_q, cnt_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  rx_ready_q, rx_ready_d;
  logic [3:0]            con_write_q, con_write_d;
  logic                  busy_q, busy_d;
  logic                  cmd_err_q, cmd_err_d;
  logic                  rx_acc, tx_acc;
  assign rx_acc    = rx_valid & rx_ready_q;
  assign tx_acc    = tx_valid_q & tx_ready;
  assign rx_ready  = rx_ready_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign con_write = con_write_q;
  assign con_addr  = addr_q;
  assign con_in    = word_q;
  assign busy      = busy_q;
  assign cmd_err   = cmd_err_q;
  // Next-state logic; word_q doubles as write assembler and read shift register
  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    ah_d       = ah_q;
    cnt_d      = cnt_q;
    bcnt_d     = bcnt_q;
    word_d     = word_q;
    addr_d     = addr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    cmd_err_d  = 1'b0;
    case (state_q)
      IDLE: if (rx_acc) begin
        if (rx_data == 8'h57 || rx_data == 8'h52) begin
          rd_d    = rx_data == 8'h52;
          state_d = AH;
        end else cmd_err_d = 1'b1;
      end
      AH: if (rx_acc) begin
        ah_d    = rx_data;
        state_d = AL;
      end
      AL: if (rx_acc) begin
        addr_d  = ADDR_BITS'({ah_q, rx_data[7:2], 2'b00});
        state_d = LEN;
      end
      LEN: if (rx_acc) begin
        cnt_d   = {rx_data == 8'h00, rx_data};
        bcnt_d  = 2'd0;
        state_d = rd_q ? RADR : WDAT;
      end
      WDAT: if (rx_acc) begin
        word_d  = {word_q[DATA_WIDTH-9:0], rx_data};
        bcnt_d  = bcnt_q + 2'd1;
        state_d = bcnt_q == 2'd3 ? WR : WDAT;
      end
      WR: begin
        cnt_d   = cnt_q - 9'd1;
        addr_d  = addr_q + ADDR_BITS'(4);
        state_d = cnt_q == 9'd1 ? ACK : WDAT;
        if (cnt_q == 9'd1) begin
          tx_valid_d = 1'b1;
          tx_data_d  = 8'h06;
        end
      end
      ACK: if (tx_acc) begin
        tx_valid_d = 1'b0;
        state_d    = IDLE;
      end
      RADR: state_d = RCAP;
      RCAP: begin
        word_d     = con_out;
        tx_data_d  = con_out[DATA_WIDTH-1 -: 8];
        tx_valid_d = 1'b1;
        bcnt_d     = 2'd0;
        state_d    = RSND;
      end
      RSND: if (tx_acc) begin
        word_d    = word_q << 8;
        tx_data_d = word_q[DATA_WIDTH-9 -: 8];
        bcnt_d    = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          tx_valid_d = 1'b0;
          cnt_d      = cnt_q - 9'd1;
          addr_d     = addr_q + ADDR_BITS'(4);
          state_d    = cnt_q == 9'd1 ? IDLE : RADR;
        end
      end
      default: state_d = IDLE;
    endcase
    rx_ready_d  = state_d inside {IDLE, AH, AL, LEN, WDAT};
    con_write_d = {4{state_d == WR}};
    busy_d      = state_d != IDLE;
  end
  // State and registered outputs; async reset cuts any write in flight
  always_ff @(posedge con_clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_q        <= 1'b0;
      ah_q        <= '0;
      cnt_q       <= '0;
      bcnt_q      <= '0;
      word_q      <= '0;
      addr_q      <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      rx_ready_q  <= 1'b0;
      con_write_q <= '0;
      busy_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      ah_q        <= ah_d;
      cnt_q       <= cnt_d;
      bcnt_q      <= bcnt_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      rx_ready_q  <= rx_ready_d;
      con_write_q <= con_write_d;
      busy_q      <= busy_d;
      cmd_err_q   <= cmd_err_d;
    end
  end
endmodule

// File: tb/tb_v_con_loader.sv
// tb_v_con_loader: scoreboard bench for the byte-stream datamem loader
module tb_v_con_loader;
  logic        con_clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  con_write;
  logic [13:0] con_addr;
  logic [31:0] con_in;
  logic [31:0] con_out;
  logic        busy;
  logic        cmd_err;
  typedef struct packed {logic [13:0] a; logic [31:0] d;} wr_t;
  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];
  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  logic rnd = 1'b0;
  logic hold = 1'b0;
  logic [7:0] hold_data = '0;
  logic [31:0] mem [0:4095];
  logic [4095:0] wrote;

  v_con_loader dut (
    .con_clk(con_clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .con_write(con_write),
    .con_addr(con_addr), .con_in(con_in), .con_out(con_out), .busy(busy), .cmd_err(cmd_err)
  );

  always #5 con_clk = ~con_clk;

  // Datamem model: one-cycle read latency; unwritten words read as CAFE0000|index
  always @(posedge con_clk) begin
    if (rst) wrote <= '0;
    else if (con_write == 4'hF) begin
      mem[con_addr[13:2]]   <= con_in;
      wrote[con_addr[13:2]] <= 1'b1;
    end
    con_out <= wrote[con_addr[13:2]] ? mem[con_addr[13:2]] : (32'hCAFE0000 | 32'(con_addr[13:2]));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: pops scoreboard on each write pulse and each tx transfer
  always @(negedge con_clk) begin
    if (rst) hold <= 1'b0;
    else begin
      if (con_write != 4'h0) begin
        if (exp_wr.size() == 0) fail("unexpected_write");
        else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("wr_en", 32'(con_write), 32'hF);
          chk("wr_addr", 32'(con_addr), 32'(e.a));
          chk("wr_data", con_in, e.d);
        end
      end
      if (hold) begin
        chk("tx_hold_valid", 32'(tx_valid), 32'd1);
        chk("tx_hold_data", 32'(tx_data), 32'(hold_data));
      end
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) fail("unexpected_tx");
        else chk("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
      end
      if (cmd_err) err_pulses++;
      hold      <= tx_valid & !tx_ready;
      hold_data <= tx_data;
    end
  end

  // Sink: always ready, or random backpressure when rnd is set
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge con_clk);
      #1;
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 2000) begin
      @(negedge con_clk);
      n++;
    end
    if (!rx_ready) begin
      fail("rx_timeout");
      rx_valid = 1'b0;
      return;
    end
    @(posedge con_clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge con_clk);
    while ((exp_wr.size() != 0 || exp_tx.size() != 0 || busy) && n < 5000) begin
      @(negedge con_clk);
      n++;
    end
    if (n >= 5000) fail("drain_timeout");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    chk({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_con_write"}, 32'(con_write), 32'd0);
    chk({tag, "_con_addr"}, 32'(con_addr), 32'd0);
    chk({tag, "_con_in"}, con_in, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cmd_err"}, 32'(cmd_err), 32'd0);
  endtask

  initial begin
    int e0;
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
    repeat (3) @(negedge con_clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge con_clk);
    chk("rx_ready_after_reset", 32'(rx_ready), 32'd1);
    chk("busy_after_reset", 32'(busy), 32'd0);
    // single word write and ack
    exp_wr.push_back('{14'h0100, 32'hDEADBEEF});
    exp_tx.push_back(8'h06);
    foreach (byte_list1[i]) send(byte_list1[i]);
    drain();
    // read back two words; second is unwritten
    foreach (rd_bytes1[i]) exp_tx.push_back(rd_bytes1[i]);
    foreach (byte_list2[i]) send(byte_list2[i]);
    drain();
    // bad command
    e0 = err_pulses;
    send(8'hA5);
    for (int i = 0; i < 4; i++) begin
      @(negedge con_clk);
      chk("bad_cmd_busy", 32'(busy), 32'd0);
    end
    chk("bad_cmd_pulses", 32'(err_pulses - e0), 32'd1);
    chk("bad_cmd_rx_ready", 32'(rx_ready), 32'd1);
    // address wrap and low-bit masking
    exp_wr.push_back('{14'h3FFC, 32'h11223344});
    exp_wr.push_back('{14'h0000, 32'h55667788});
    exp_tx.push_back(8'h06);
    foreach (byte_list3[i]) send(byte_list3[i]);
    drain();
    // read across the wrap under random backpressure
    rnd = 1'b1;
    for (int i = 0; i < 8; i++) exp_tx.push_back(8'(8'h11 * (i + 1)));
    foreach (byte_list4[i]) send(byte_list4[i]);
    drain();
    rnd = 1'b0;
    // LEN=0 means 256 words
    for (int i = 0; i < 256; i++) exp_wr.push_back('{14'(i * 4), {8'(i), 8'hA0, 8'h5F, ~8'(i)}});
    exp_tx.push_back(8'h06);
    send(8'h57); send(8'h00); send(8'h00); send(8'h00);
    for (int i = 0; i < 256; i++) begin
      send(8'(i)); send(8'hA0); send(8'h5F); send(~8'(i));
    end
    drain();
    // reset in the middle of a write word
    send(8'h57); send(8'h02); send(8'h00); send(8'h01); send(8'hAA); send(8'hBB);
    @(negedge con_clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    repeat (2) @(negedge con_clk);
    rst = 1'b0;
    @(negedge con_clk);
    chk("rx_ready_after_midreset", 32'(rx_ready), 32'd1);
    chk("busy_after_midreset", 32'(busy), 32'd0);
    repeat (3) @(negedge con_clk);
    // resent command completes normally
    exp_wr.push_back('{14'h0200, 32'h01020304});
    exp_tx.push_back(8'h06);
    foreach (byte_list5[i]) send(byte_list5[i]);
    drain();
    chk("total_cmd_err_pulses", 32'(err_pulses), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  logic [7:0] byte_list1[8] = '{8'h57, 8'h01, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
  logic [7:0] byte_list2[4] = '{8'h52, 8'h01, 8'h00, 8'h02};
  logic [7:0] rd_bytes1[8]  = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'h00, 8'h41};
  logic [7:0] byte_list3[12] = '{8'h57, 8'h3F, 8'hFF, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                                 8'h55, 8'h66, 8'h77, 8'h88};
  logic [7:0] byte_list4[4] = '{8'h52, 8'h3F, 8'hFF, 8'h02};
  logic [7:0] byte_list5[8] = '{8'h57, 8'h02, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
endmodule
